// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register for the 5-stage RV32I core.
// Captures register-file read data and decode control, detects load-use
// hazards, inserts bubbles, honours flush/hold and registers the Execute
// operand forwarding selects. Saturating bubble/flush counters for debug.

// Forwarding select for one source operand.
// 0 = register data, 1 = from Memory stage, 2 = from Writeback stage.
module decode_execute_reg_fwd #(
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic [ADDRESS_WIDTH-1:0] rs,
  input  logic                     uses,
  input  logic                     ex_valid,
  input  logic                     ex_regwrite,
  input  logic [ADDRESS_WIDTH-1:0] ex_rd,
  input  logic                     mem_regwrite,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  output logic [1:0]               sel
);

  // Younger producer (now in Execute, next in Memory) wins over the older one.
  // rs != 0 also implies the matching rd is non-zero.
  always_comb begin
    sel = 2'd0;
    if (uses && (rs != '0)) begin
      if (ex_valid && ex_regwrite && (ex_rd == rs))
        sel = 2'd1;
      else if (mem_regwrite && (mem_rd == rs))
        sel = 2'd2;
    end
  end

endmodule

module decode_execute_reg #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iValid,
  input  logic [ADDRESS_WIDTH-1:0] iRs1,
  input  logic [ADDRESS_WIDTH-1:0] iRs2,
  input  logic                     iUsesRs1,
  input  logic                     iUsesRs2,
  input  logic [ADDRESS_WIDTH-1:0] iRd,
  input  logic [DATA_WIDTH-1:0]    iRegData1,
  input  logic [DATA_WIDTH-1:0]    iRegData2,
  input  logic [DATA_WIDTH-1:0]    iImm,
  input  logic [DATA_WIDTH-1:0]    iPC,
  input  logic [7:0]               iCtrl,
  input  logic                     iRegWrite,
  input  logic                     iMemRead,
  input  logic                     iMemWrite,
  input  logic [ADDRESS_WIDTH-1:0] iRdM,
  input  logic                     iRegWriteM,
  input  logic                     iFlush,
  input  logic                     iHold,
  output logic                     oValid,
  output logic [ADDRESS_WIDTH-1:0] oRs1,
  output logic [ADDRESS_WIDTH-1:0] oRs2,
  output logic [ADDRESS_WIDTH-1:0] oRd,
  output logic [DATA_WIDTH-1:0]    oRegData1,
  output logic [DATA_WIDTH-1:0]    oRegData2,
  output logic [DATA_WIDTH-1:0]    oImm,
  output logic [DATA_WIDTH-1:0]    oPC,
  output logic [7:0]               oCtrl,
  output logic                     oRegWrite,
  output logic                     oMemRead,
  output logic                     oMemWrite,
  output logic [1:0]               oFwdA,
  output logic [1:0]               oFwdB,
  output logic                     oStall,
  output logic [CNT_WIDTH-1:0]     oBubbleCount,
  output logic [CNT_WIDTH-1:0]     oFlushCount
);

  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    data1;
    logic [DATA_WIDTH-1:0]    data2;
    logic [DATA_WIDTH-1:0]    imm;
    logic [DATA_WIDTH-1:0]    pc;
    logic [7:0]               ctrl;
    logic                     regwrite;
    logic                     memread;
    logic                     memwrite;
    logic [1:0]               fwda;
    logic [1:0]               fwdb;
  } ex_t;

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;
  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_FLUSH   = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_BUBBLE  = 2'd3
  } act_t;

  ex_t    ex_q;
  ex_t    ex_cap;
  state_t state_q, state_nxt;
  act_t   act;
  logic   hazard;

  logic [NUM_SRC-1:0][ADDRESS_WIDTH-1:0] src_rs;
  logic [NUM_SRC-1:0]                    src_use;
  logic [NUM_SRC-1:0][1:0]               fwd_sel;

  // Load in Execute whose rd is read by the instruction in Decode.
  assign hazard = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & iValid &
                  ((iUsesRs1 & (ex_q.rd == iRs1)) | (iUsesRs2 & (ex_q.rd == iRs2)));

  // A flush discards Decode anyway and a hold freezes everything, so
  // neither needs the upstream freeze.
  assign oStall = hazard & ~iFlush & ~iHold;

  assign src_rs  = {iRs2, iRs1};
  assign src_use = {iUsesRs2, iUsesRs1};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    decode_execute_reg_fwd #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd (
      .rs          (src_rs[g]),
      .uses        (src_use[g]),
      .ex_valid    (ex_q.valid),
      .ex_regwrite (ex_q.regwrite),
      .ex_rd       (ex_q.rd),
      .mem_regwrite(iRegWriteM),
      .mem_rd      (iRdM),
      .sel         (fwd_sel[g])
    );
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) state_q <= RUN;
    else      state_q <= state_nxt;
  end

  // Next state: flush always returns to RUN; hold freezes the state.
  always_comb begin
    state_nxt = state_q;
    if (iFlush)       state_nxt = RUN;
    else if (iHold)   state_nxt = state_q;
    else if (hazard)  state_nxt = BUBBLE;
    else              state_nxt = RUN;
  end

  // Per-edge action in priority order. In BUBBLE Execute holds a bubble
  // (memread=0), so hazard is structurally low there.
  always_comb begin
    act = ACT_CAPTURE;
    if (iFlush)      act = ACT_FLUSH;
    else if (iHold)  act = ACT_HOLD;
    else if (hazard) act = ACT_BUBBLE;
  end

  // Payload captured on a normal advance.
  always_comb begin
    ex_cap          = '0;
    ex_cap.valid    = iValid;
    ex_cap.rs1      = iRs1;
    ex_cap.rs2      = iRs2;
    ex_cap.rd       = iRd;
    ex_cap.data1    = iRegData1;
    ex_cap.data2    = iRegData2;
    ex_cap.imm      = iImm;
    ex_cap.pc       = iPC;
    ex_cap.ctrl     = iCtrl;
    ex_cap.regwrite = iRegWrite;
    ex_cap.memread  = iMemRead;
    ex_cap.memwrite = iMemWrite;
    ex_cap.fwda     = fwd_sel[0];
    ex_cap.fwdb     = fwd_sel[1];
  end

  // Execute-stage register; a bubble is the all-zero payload.
  always_ff @(posedge iClk) begin
    if (iRst) ex_q <= '0;
    else begin
      case (act)
        ACT_FLUSH,
        ACT_BUBBLE:  ex_q <= '0;
        ACT_CAPTURE: ex_q <= ex_cap;
        default:     ex_q <= ex_q;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oBubbleCount <= '0;
      oFlushCount  <= '0;
    end else begin
      if ((act == ACT_FLUSH) && (oFlushCount != '1))
        oFlushCount <= oFlushCount + CNT_WIDTH'(1);
      if ((act == ACT_BUBBLE) && (oBubbleCount != '1))
        oBubbleCount <= oBubbleCount + CNT_WIDTH'(1);
    end
  end

  assign oValid    = ex_q.valid;
  assign oRs1      = ex_q.rs1;
  assign oRs2      = ex_q.rs2;
  assign oRd       = ex_q.rd;
  assign oRegData1 = ex_q.data1;
  assign oRegData2 = ex_q.data2;
  assign oImm      = ex_q.imm;
  assign oPC       = ex_q.pc;
  assign oCtrl     = ex_q.ctrl;
  assign oRegWrite = ex_q.regwrite;
  assign oMemRead  = ex_q.memread;
  assign oMemWrite = ex_q.memwrite;
  assign oFwdA     = ex_q.fwda;
  assign oFwdB     = ex_q.fwdb;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Bench for decode_execute_reg: directed load-use / forwarding / flush /
// hold / saturation scenarios, then randomized traffic, all checked each
// cycle against a behavioural model of the Execute slot.
module tb_decode_execute_reg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          iClk = 1'b0;
  logic          iRst, iValid, iUsesRs1, iUsesRs2;
  logic [AW-1:0] iRs1, iRs2, iRd, iRdM;
  logic [DW-1:0] iRegData1, iRegData2, iImm, iPC;
  logic [7:0]    iCtrl;
  logic          iRegWrite, iMemRead, iMemWrite, iRegWriteM, iFlush, iHold;
  logic          oValid, oRegWrite, oMemRead, oMemWrite, oStall;
  logic [AW-1:0] oRs1, oRs2, oRd;
  logic [DW-1:0] oRegData1, oRegData2, oImm, oPC;
  logic [7:0]    oCtrl;
  logic [1:0]    oFwdA, oFwdB;
  logic [CW-1:0] oBubbleCount, oFlushCount;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model of what Execute must hold.
  bit          m_valid, m_regwrite, m_memread, m_memwrite;
  bit [AW-1:0] m_rs1, m_rs2, m_rd;
  bit [DW-1:0] m_d1, m_d2, m_imm, m_pc;
  bit [7:0]    m_ctrl;
  int          m_fwda, m_fwdb, m_bc, m_fc;

  always #5 iClk = ~iClk;

  decode_execute_reg #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iRs1(iRs1), .iRs2(iRs2),
    .iUsesRs1(iUsesRs1), .iUsesRs2(iUsesRs2), .iRd(iRd),
    .iRegData1(iRegData1), .iRegData2(iRegData2), .iImm(iImm), .iPC(iPC),
    .iCtrl(iCtrl), .iRegWrite(iRegWrite), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
    .iRdM(iRdM), .iRegWriteM(iRegWriteM), .iFlush(iFlush), .iHold(iHold),
    .oValid(oValid), .oRs1(oRs1), .oRs2(oRs2), .oRd(oRd),
    .oRegData1(oRegData1), .oRegData2(oRegData2), .oImm(oImm), .oPC(oPC),
    .oCtrl(oCtrl), .oRegWrite(oRegWrite), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .oFwdA(oFwdA), .oFwdB(oFwdB), .oStall(oStall),
    .oBubbleCount(oBubbleCount), .oFlushCount(oFlushCount)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load-use: a load sits in Execute and Decode reads its destination.
  function automatic bit m_hazard();
    return m_valid && m_memread && (m_rd != 0) && iValid &&
           ((iUsesRs1 && (m_rd == iRs1)) || (iUsesRs2 && (m_rd == iRs2)));
  endfunction

  // Where the operand for register rs will come from next cycle.
  function automatic int fwd_of(input bit [AW-1:0] rs, input bit uses);
    if (!uses || rs == 0)                     return 0;
    if (m_valid && m_regwrite && m_rd == rs)  return 1;
    if (iRegWriteM && iRdM == rs)             return 2;
    return 0;
  endfunction

  task automatic m_clear();
    m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc = 0;
    m_ctrl = 0; m_fwda = 0; m_fwdb = 0;
  endtask

  task automatic model_update();
    int fa, fb;
    bit haz;
    fa  = fwd_of(iRs1, iUsesRs1);
    fb  = fwd_of(iRs2, iUsesRs2);
    haz = m_hazard();
    if (iRst) begin
      m_clear(); m_bc = 0; m_fc = 0;
    end else if (iFlush) begin
      m_clear(); if (m_fc < CMAX) m_fc++;
    end else if (iHold) begin
      // frozen
    end else if (haz) begin
      m_clear(); if (m_bc < CMAX) m_bc++;
    end else begin
      m_valid = iValid; m_rs1 = iRs1; m_rs2 = iRs2; m_rd = iRd;
      m_d1 = iRegData1; m_d2 = iRegData2; m_imm = iImm; m_pc = iPC;
      m_ctrl = iCtrl; m_regwrite = iRegWrite; m_memread = iMemRead;
      m_memwrite = iMemWrite; m_fwda = fa; m_fwdb = fb;
    end
  endtask

  task automatic cmp_all();
    chk("oValid", oValid, m_valid);
    chk("oRs1", oRs1, m_rs1);
    chk("oRs2", oRs2, m_rs2);
    chk("oRd", oRd, m_rd);
    chk("oRegData1", oRegData1, m_d1);
    chk("oRegData2", oRegData2, m_d2);
    chk("oImm", oImm, m_imm);
    chk("oPC", oPC, m_pc);
    chk("oCtrl", oCtrl, m_ctrl);
    chk("oRegWrite", oRegWrite, m_regwrite);
    chk("oMemRead", oMemRead, m_memread);
    chk("oMemWrite", oMemWrite, m_memwrite);
    chk("oFwdA", oFwdA, m_fwda);
    chk("oFwdB", oFwdB, m_fwdb);
    chk("oBubbleCount", oBubbleCount, m_bc);
    chk("oFlushCount", oFlushCount, m_fc);
    chk("oStall", oStall, m_hazard() && !iFlush && !iHold);
  endtask

  // One clock: model advances on the edge, outputs compared 2ns later.
  task automatic step();
    @(posedge iClk);
    model_update();
    #2;
    if (chk_en) cmp_all();
  endtask

  task automatic clear_in();
    iRst = 0; iValid = 0; iRs1 = 0; iRs2 = 0; iUsesRs1 = 0; iUsesRs2 = 0; iRd = 0;
    iRegData1 = 0; iRegData2 = 0; iImm = 0; iPC = 0; iCtrl = 0;
    iRegWrite = 0; iMemRead = 0; iMemWrite = 0; iRdM = 0; iRegWriteM = 0;
    iFlush = 0; iHold = 0;
  endtask

  task automatic rand_data();
    iValid = ($urandom_range(3) != 0);
    iRs1 = AW'($urandom_range(7)); iRs2 = AW'($urandom_range(7));
    iUsesRs1 = ($urandom_range(3) != 0); iUsesRs2 = ($urandom_range(1) != 0);
    iRd = AW'($urandom_range(7));
    iRegData1 = $urandom; iRegData2 = $urandom; iImm = $urandom; iPC = $urandom;
    iCtrl = 8'($urandom_range(255));
    iRegWrite = ($urandom_range(1) != 0); iMemRead = ($urandom_range(2) == 0);
    iMemWrite = ($urandom_range(3) == 0);
    iRdM = AW'($urandom_range(7)); iRegWriteM = ($urandom_range(1) != 0);
  endtask

  task automatic set_lw5();
    clear_in(); iValid = 1; iMemRead = 1; iRegWrite = 1; iRd = 5; iPC = 32'h40;
  endtask

  task automatic set_alu(input int rd, input int rs1, input int rs2);
    clear_in(); iValid = 1; iRegWrite = 1; iRd = AW'(rd);
    iRs1 = AW'(rs1); iRs2 = AW'(rs2); iUsesRs1 = 1; iUsesRs2 = 1;
    iRegData1 = 32'h1111; iRegData2 = 32'h2222; iCtrl = 8'h03;
  endtask

  initial begin
    clear_in();
    // Reset with arbitrary inputs.
    rand_data(); iFlush = 1; iHold = 1; iRst = 1;
    step(); step();
    m_clear(); m_bc = 0; m_fc = 0;
    chk_en = 1;
    iRst = 0; iFlush = 0; iHold = 0; iValid = 0;
    #1;
    chk("rst_valid", oValid, 0);
    chk("rst_pc", oPC, 0);
    chk("rst_fwd", {oFwdA, oFwdB}, 0);
    chk("rst_counts", {oBubbleCount, oFlushCount}, 0);
    chk("rst_stall", oStall, 0);

    // lw x5 ; add x6,x5,x7
    set_lw5(); step();
    set_alu(6, 5, 7); #1;
    chk("lu_stall", oStall, 1);
    step();
    chk("lu_bubble_valid", oValid, 0);
    chk("lu_bubble_cnt", oBubbleCount, 1);
    chk("lu_stall_gone", oStall, 0);
    iRdM = 5; iRegWriteM = 1;
    step();
    chk("lu_add_valid", oValid, 1);
    chk("lu_add_rd", oRd, 6);
    chk("lu_fwda_wb", oFwdA, 2);
    chk("lu_fwdb", oFwdB, 0);

    // add x3 ; sub x4,x3,x3  then rs1=x0
    set_alu(3, 1, 2); step();
    set_alu(4, 3, 3); step();
    chk("ex_fwda_mem", oFwdA, 1);
    chk("ex_fwdb_mem", oFwdB, 1);
    set_alu(3, 1, 2); step();
    set_alu(4, 0, 3); step();
    chk("x0_fwda", oFwdA, 0);
    chk("x0_fwdb", oFwdB, 1);

    // Hazard together with flush.
    set_lw5(); step();
    set_alu(6, 5, 7); iFlush = 1; #1;
    chk("fl_stall", oStall, 0);
    step();
    chk("fl_valid", oValid, 0);
    chk("fl_flushcnt", oFlushCount, 1);
    chk("fl_bubblecnt", oBubbleCount, 1);

    // Hold for 3 cycles with changing inputs.
    clear_in(); iValid = 1; iRd = 9; iImm = 32'h1234; iPC = 32'h100; iCtrl = 8'hA5;
    step();
    repeat (3) begin
      rand_data(); iHold = 1; iRst = 0; iFlush = 0;
      step();
      chk("hold_pc", oPC, 32'h100);
      chk("hold_imm", oImm, 32'h1234);
      chk("hold_ctrl", oCtrl, 8'hA5);
    end
    clear_in(); iValid = 1; iPC = 32'h200; step();
    chk("hold_release_pc", oPC, 32'h200);

    // 20 load-use bubbles saturate the 4-bit counter.
    repeat (20) begin
      set_lw5(); step();
      set_alu(6, 5, 0); step();
    end
    chk("sat_bubble", oBubbleCount, 15);

    // Randomized traffic.
    repeat (3000) begin
      rand_data();
      iRst = ($urandom_range(99) == 0);
      iFlush = ($urandom_range(9) == 0);
      iHold = ($urandom_range(7) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- Decode→Execute pipeline register for the 5-stage RV32I core; sits directly downstream of the register file.
- Captures the register-file read data, which the register file updates on negedge, together with the decode control fields at posedge.
- Detects load-use hazards, inserts bubbles, honours flush and hold, and produces registered forwarding selects for the Execute-stage operand muxes.
- Keeps saturating bubble and flush counters for performance debug.

Parameters:
- DATA_WIDTH, 32, operand, PC and immediate width.
- ADDRESS_WIDTH, 5, register address width.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- iClk  in  1  clock; all state updates on posedge.
- iRst  in  1  synchronous active-high reset.
- iValid  in  1  Decode holds a real instruction.
- iRs1, iRs2  in  ADDRESS_WIDTH  source register addresses.
- iUsesRs1, iUsesRs2  in  1  instruction actually reads rs1 / rs2.
- iRd  in  ADDRESS_WIDTH  destination register.
- iRegData1, iRegData2  in  DATA_WIDTH  register-file read data.
- iImm, iPC  in  DATA_WIDTH  immediate and PC.
- iCtrl  in  8  packed ALU/branch control, passed through.
- iRegWrite, iMemRead, iMemWrite  in  1  decoded control bits.
- iRdM  in  ADDRESS_WIDTH  destination of the instruction in Memory.
- iRegWriteM  in  1  the instruction in Memory writes a register.
- iFlush  in  1  branch/jump taken in Execute.
- iHold  in  1  global stall (memory busy).
- oValid, oRs1, oRs2, oRd, oRegData1, oRegData2, oImm, oPC, oCtrl, oRegWrite, oMemRead, oMemWrite  out  as inputs  registered Execute-stage copies.
- oFwdA, oFwdB  out  2  registered selects: 0 = register data, 1 = from Memory (ALU result), 2 = from Writeback.
- oStall  out  1  combinational; freeze PC and the Fetch→Decode register.
- oBubbleCount, oFlushCount  out  CNT_WIDTH  saturating counters.

Behaviour:
- Reset (iRst at posedge):
  - All outputs go to 0, including oValid=0, oFwdA/B=0 and both counters.
  - The state machine goes to RUN.
  - Reset overrides every other input.
- Hazard, combinational:
  - Condition: oValid & oMemRead & oRd≠0 & iValid & ((iUsesRs1 & oRd==iRs1) | (iUsesRs2 & oRd==iRs2)).
  - oStall = hazard & ~iFlush & ~iHold.
- Bubble definition: oValid, oRegWrite, oMemRead, oMemWrite, oCtrl, oFwdA and oFwdB are forced to 0. Data fields are don't-care and are driven to 0.
- Per-posedge priority:
  1. iRst.
  2. iFlush: load a bubble; oFlushCount += 1.
  3. iHold: all outputs keep their values; counters unchanged.
  4. Hazard: load a bubble; oBubbleCount += 1.
  5. Otherwise capture all inputs, with oValid = iValid.
- State machine:
  - States: RUN, BUBBLE.
  - RUN → BUBBLE on a hazard bubble. BUBBLE → RUN on the next non-held posedge. The state is held while iHold.
  - A hazard cannot re-fire in BUBBLE because oMemRead=0, so each load-use costs exactly 1 cycle.
  - Flush in either state → RUN.
- Forwarding selects, computed from pre-edge values and registered on a normal capture:
  - FwdA = 1 if oValid & oRegWrite & oRd≠0 & oRd==iRs1 (the current Execute instruction will be in Memory).
  - Else FwdA = 2 if iRegWriteM & iRdM≠0 & iRdM==iRs1 (it will be in Writeback).
  - Else FwdA = 0.
  - FwdB is computed the same way against iRs2.
  - Memory takes priority over Writeback.
  - Select is 0 when the source register is x0 or the use flag is clear.
- Counters saturate at all-ones and never wrap.
- Same-cycle events:
  - iFlush together with a hazard: flush wins, oStall=0, only oFlushCount increments.
  - iHold together with a hazard: nothing changes and oStall=0; the hazard is re-evaluated after the hold releases.
- Latency: 1 cycle from input to output.

Test Plan:
- Reset with arbitrary inputs, then iRst=1 for 2 cycles → every output 0, counters 0, oStall=0.
- lw x5 (oMemRead=1, oRd=5) followed by add x6,x5,x7 (iRs1=5, iUsesRs1=1) → oStall=1 for 1 cycle; next cycle oValid=0 and oBubbleCount=1; the following cycle captures the add with oFwdA=2 once the load is in Memory.
- add x3 in Execute, then sub x4,x3,x3 → oFwdA=1 and oFwdB=1 after the edge; with iRs1=0 instead → oFwdA=0.
- Hazard and iFlush in the same cycle → oStall=0, bubble loaded, oFlushCount=1, oBubbleCount unchanged.
- iHold=1 for 3 cycles with changing inputs → outputs frozen at the pre-hold values; on release, capture resumes.
- CNT_WIDTH=4: force 20 bubbles → oBubbleCount saturates at 15.
